// File: rtl/pid_core_mux4.sv
// Four-channel time-multiplexed PID controller sharing one multiplier.
// Define PID_DERIV_EN to build the derivative path (kd term, e_prev storage, MAC_D state).
module pid_core_mux4 #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned OUT_MAX    = 1024,
  parameter int unsigned INTEG_MAX  = 65535
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  input  logic [4*DATA_WIDTH-1:0] sp_i,
  input  logic [4*DATA_WIDTH-1:0] fb_i,
  input  logic [DATA_WIDTH-1:0]   kp,
  input  logic [DATA_WIDTH-1:0]   ki,
  input  logic [DATA_WIDTH-1:0]   kd,
  input  logic [3:0]              stop,
  output logic                    busy,
  output logic                    u_valid_o,
  output logic [2:0]              u_chn_o,
  output logic [DATA_WIDTH-1:0]   u_data_o
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned IW = 24;
  localparam int unsigned MW = IW + DW + 1;
  localparam int unsigned AW = 44;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StErr   = 3'd1;
  localparam logic [2:0] StInteg = 3'd2;
  localparam logic [2:0] StMacP  = 3'd3;
  localparam logic [2:0] StMacI  = 3'd4;
`ifdef PID_DERIV_EN
  localparam logic [2:0] StMacD  = 3'd5;
`endif
  localparam logic [2:0] StOut   = 3'd6;

  localparam logic signed [IW:0]   IntegMax = (IW+1)'(INTEG_MAX);
  localparam logic signed [IW:0]   IntegMin = -IntegMax;
  localparam logic signed [AW-1:0] OutMax   = AW'(OUT_MAX);
  localparam logic signed [AW-1:0] OutMin   = -OutMax;

  logic [2:0]             state_q, state_d;
  logic [1:0]             chn_q;
  logic signed [DW-1:0]   sp_q [4];
  logic signed [DW-1:0]   fb_q [4];
  logic [DW-1:0]          kp_q, ki_q;
  logic [3:0]             stop_q;
  logic signed [DW-1:0]   e_q;
  logic signed [IW-1:0]   integ_q [4];
  logic signed [AW-1:0]   acc_q;
  logic                   u_valid_q;
  logic [2:0]             u_chn_q;
  logic [DW-1:0]          u_data_q;

`ifdef PID_DERIV_EN
  logic [DW-1:0]          kd_q;
  logic signed [DW-1:0]   e_prev_q [4];
  logic signed [DW:0]     d_q;
`else
  logic                   unused_kd;
  assign unused_kd = ^kd;
`endif

  // Error with 17-bit headroom, saturated back to 16 bits.
  logic signed [DW:0]   diff;
  logic signed [DW-1:0] e_sat;
  always_comb begin
    diff = {sp_q[chn_q][DW-1], sp_q[chn_q]} - {fb_q[chn_q][DW-1], fb_q[chn_q]};
    if (diff[DW] != diff[DW-1]) begin
      e_sat = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      e_sat = diff[DW-1:0];
    end
  end

  logic signed [IW:0]   integ_sum;
  logic signed [IW-1:0] integ_next;
  always_comb begin
    integ_sum = {integ_q[chn_q][IW-1], integ_q[chn_q]} + {{(IW+1-DW){e_q[DW-1]}}, e_q};
    if (integ_sum > IntegMax) begin
      integ_next = IntegMax[IW-1:0];
    end else if (integ_sum < IntegMin) begin
      integ_next = IntegMin[IW-1:0];
    end else begin
      integ_next = integ_sum[IW-1:0];
    end
  end

  // Shared multiplier: signed operand times zero-extended gain.
  logic signed [IW-1:0] mul_a;
  logic [DW-1:0]        mul_b;
  logic signed [MW-1:0] prod;
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      StMacP: begin
        mul_a = {{(IW-DW){e_q[DW-1]}}, e_q};
        mul_b = kp_q;
      end
      StMacI: begin
        mul_a = integ_q[chn_q];
        mul_b = ki_q;
      end
`ifdef PID_DERIV_EN
      StMacD: begin
        mul_a = {{(IW-DW-1){d_q[DW]}}, d_q};
        mul_b = kd_q;
      end
`endif
      default: ;
    endcase
  end
  assign prod = MW'(mul_a) * $signed({{(MW-DW){1'b0}}, mul_b});

  logic signed [AW-1:0] acc_shr, u_sat;
  always_comb begin
    acc_shr = acc_q >>> FRAC_BITS;
    if (acc_shr > OutMax) begin
      u_sat = OutMax;
    end else if (acc_shr < OutMin) begin
      u_sat = OutMin;
    end else begin
      u_sat = acc_shr;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StErr;
      StErr:   state_d = StInteg;
      StInteg: state_d = StMacP;
      StMacP:  state_d = StMacI;
`ifdef PID_DERIV_EN
      StMacI:  state_d = StMacD;
      StMacD:  state_d = StOut;
`else
      StMacI:  state_d = StOut;
`endif
      StOut:   state_d = (chn_q == 2'd3) ? StIdle : StErr;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      chn_q     <= '0;
      kp_q      <= '0;
      ki_q      <= '0;
      stop_q    <= '0;
      e_q       <= '0;
      acc_q     <= '0;
      u_valid_q <= 1'b0;
      u_chn_q   <= '0;
      u_data_q  <= '0;
      for (int i = 0; i < 4; i++) begin
        sp_q[i]    <= '0;
        fb_q[i]    <= '0;
        integ_q[i] <= '0;
      end
`ifdef PID_DERIV_EN
      kd_q <= '0;
      d_q  <= '0;
      for (int i = 0; i < 4; i++) e_prev_q[i] <= '0;
`endif
    end else begin
      state_q   <= state_d;
      u_valid_q <= 1'b0;
      case (state_q)
        StIdle: if (start) begin
          chn_q  <= '0;
          kp_q   <= kp;
          ki_q   <= ki;
          stop_q <= stop;
          for (int i = 0; i < 4; i++) begin
            sp_q[i] <= sp_i[i*DW +: DW];
            fb_q[i] <= fb_i[i*DW +: DW];
          end
`ifdef PID_DERIV_EN
          kd_q <= kd;
`endif
        end
        StErr: begin
          e_q <= e_sat;
          if (stop_q[chn_q]) begin
            integ_q[chn_q] <= '0;
`ifdef PID_DERIV_EN
            e_prev_q[chn_q] <= '0;
`endif
          end
        end
        // A stopped channel keeps its state cleared for the whole frame.
        StInteg: if (!stop_q[chn_q]) begin
          integ_q[chn_q] <= integ_next;
`ifdef PID_DERIV_EN
          d_q             <= {e_q[DW-1], e_q} - {e_prev_q[chn_q][DW-1], e_prev_q[chn_q]};
          e_prev_q[chn_q] <= e_q;
`endif
        end
        StMacP: acc_q <= AW'(prod);
        StMacI: acc_q <= acc_q + AW'(prod);
`ifdef PID_DERIV_EN
        StMacD: acc_q <= acc_q + AW'(prod);
`endif
        StOut: begin
          u_valid_q <= 1'b1;
          u_chn_q   <= {1'b0, chn_q};
          u_data_q  <= stop_q[chn_q] ? '0 : u_sat[DW-1:0];
          chn_q     <= chn_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Stays high through the final output strobe.
  assign busy      = (state_q != StIdle) | u_valid_q;
  assign u_valid_o = u_valid_q;
  assign u_chn_o   = u_chn_q;
  assign u_data_o  = u_data_q;

endmodule

// File: tb/tb_pid_core_mux4.sv
// Scoreboard bench for pid_core_mux4: behavioural model pushes expected outputs,
// a monitor pops and compares on every u_valid_o strobe.
module tb_pid_core_mux4;

`ifdef PID_DERIV_EN
  localparam int P     = 6;
  localparam bit DERIV = 1'b1;
`else
  localparam int P     = 5;
  localparam bit DERIV = 1'b0;
`endif
  localparam int FRAME = 4 * P + 1;
  localparam longint IMAX = 65535;
  localparam longint OMAX = 1024;

  logic        clk, rstn, start;
  logic [63:0] sp_i, fb_i;
  logic [15:0] kp, ki, kd;
  logic [3:0]  stop;
  logic        busy, u_valid_o;
  logic [2:0]  u_chn_o;
  logic [15:0] u_data_o;

  pid_core_mux4 #(
    .DATA_WIDTH(16),
    .FRAC_BITS (8),
    .OUT_MAX   (1024),
    .INTEG_MAX (65535)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .sp_i     (sp_i),
    .fb_i     (fb_i),
    .kp       (kp),
    .ki       (ki),
    .kd       (kd),
    .stop     (stop),
    .busy     (busy),
    .u_valid_o(u_valid_o),
    .u_chn_o  (u_chn_o),
    .u_data_o (u_data_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int chn;
    int data;
    int at;
  } exp_t;
  exp_t sb[$];
  exp_t mx;

  int n_cmp = 0;
  int n_bad = 0;
  int last_acc = 0;

  longint m_integ[4];
  longint m_eprev[4];
  int     exp_u[4];

  task automatic check(input string name, input longint got, input longint want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && u_valid_o) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mx = sb.pop_front();
        check("out_chn", u_chn_o, mx.chn);
        check("out_data", $signed(u_data_o), mx.data);
        check("out_cycle", cyc, mx.at);
      end
    end
  end

  // One frame of the controller computed with plain integer arithmetic.
  task automatic model_frame(input logic [63:0] s, input logic [63:0] f, input logic [15:0] gp,
                             input logic [15:0] gi, input logic [15:0] gd, input logic [3:0] st);
    for (int n = 0; n < 4; n++) begin
      longint e, d, acc, q;
      e = longint'($signed(s[16*n +: 16])) - longint'($signed(f[16*n +: 16]));
      if (e > 32767) e = 32767;
      if (e < -32768) e = -32768;
      if (st[n]) begin
        m_integ[n] = 0;
        m_eprev[n] = 0;
        exp_u[n]   = 0;
      end else begin
        m_integ[n] = m_integ[n] + e;
        if (m_integ[n] > IMAX) m_integ[n] = IMAX;
        if (m_integ[n] < -IMAX) m_integ[n] = -IMAX;
        d = e - m_eprev[n];
        m_eprev[n] = e;
        acc = longint'(gp) * e + longint'(gi) * m_integ[n];
        if (DERIV) acc = acc + longint'(gd) * d;
        q = acc >>> 8;
        if (q > OMAX) q = OMAX;
        if (q < -OMAX) q = -OMAX;
        exp_u[n] = int'(q);
      end
    end
  endtask

  task automatic wait_cyc(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic run_frame(input logic [63:0] s, input logic [63:0] f, input logic [15:0] gp,
                           input logic [15:0] gi, input logic [15:0] gd, input logic [3:0] st,
                           input bit b2b, input bit poke, input bit abort);
    int acc;
    model_frame(s, f, gp, gi, gd, st);
    sp_i = s; fb_i = f; kp = gp; ki = gi; kd = gd; stop = st;
    start = 1'b1;
    @(posedge clk);
    #1;
    acc   = cyc;
    start = 1'b0;
    if (b2b) check("b2b_accept_cycle", acc, last_acc + FRAME);
    last_acc = acc;
    for (int n = 0; n < 4; n++) begin
      if (!abort || n == 0) sb.push_back('{n, exp_u[n], acc + P * (n + 1)});
    end
    // Inputs wander during the frame; the snapshot must hide this.
    sp_i = {$urandom, $urandom};
    fb_i = {$urandom, $urandom};
    kp = 16'($urandom); ki = 16'($urandom); kd = 16'($urandom); stop = 4'($urandom);
    if (poke) begin
      wait_cyc(acc + 2);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    if (abort) begin
      wait_cyc(acc + 8);
      @(posedge clk);
      #1;
      rstn = 1'b0;
      for (int n = 0; n < 4; n++) begin
        m_integ[n] = 0;
        m_eprev[n] = 0;
      end
      #1;
      check("abort_busy", busy, 0);
      check("abort_valid", u_valid_o, 0);
      check("abort_chn", u_chn_o, 0);
      check("abort_data", u_data_o, 0);
      check("abort_sb_drained", sb.size(), 0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
    end else begin
      wait_cyc(acc + FRAME - 1);
      check("busy_last_cycle", busy, 1);
    end
  endtask

  task automatic finish_idle();
    @(negedge clk);
    check("busy_low_end", busy, 0);
    check("valid_low_end", u_valid_o, 0);
    check("sb_drained", sb.size(), 0);
  endtask

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic clear_all();
    run_frame(64'd0, 64'd0, 16'd0, 16'd0, 16'd0, 4'hF, 1'b0, 1'b0, 1'b0);
    finish_idle();
  endtask

  logic [63:0] rs, rf;
  logic [15:0] rp, ri, rd;
  logic [3:0]  rst4;
  bit          open_frame;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk = 1'b0; rstn = 1'b0; start = 1'b0;
    sp_i = '0; fb_i = '0; kp = '0; ki = '0; kd = '0; stop = '0;
    for (int n = 0; n < 4; n++) begin
      m_integ[n] = 0;
      m_eprev[n] = 0;
    end
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_valid", u_valid_o, 0);
    check("reset_chn", u_chn_o, 0);
    check("reset_data", u_data_o, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Proportional path and saturation of both signs
    run_frame(pk(100, 0, 0, 0), 64'd0, 16'd256, 16'd0, 16'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    finish_idle();
    run_frame(pk(2000, -2000, 0, 0), 64'd0, 16'd256, 16'd0, 16'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    finish_idle();

    // Integral, back-to-back frames
    clear_all();
    run_frame(pk(10, 10, 10, 10), 64'd0, 16'd0, 16'd256, 16'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    run_frame(pk(10, 10, 10, 10), 64'd0, 16'd0, 16'd256, 16'd0, 4'h0, 1'b1, 1'b0, 1'b0);
    run_frame(pk(10, 10, 10, 10), 64'd0, 16'd0, 16'd256, 16'd0, 4'h0, 1'b1, 1'b0, 1'b0);
    finish_idle();

    // Error saturation and integrator clamp at the default limit
    clear_all();
    for (int k = 0; k < 3; k++) begin
      run_frame(pk(32767, 32767, -32768, 0), pk(-32768, -32768, 32767, 0), 16'd0, 16'd1,
                16'd0, 4'h0, k > 0, 1'b0, 1'b0);
    end
    finish_idle();

    // Derivative
    clear_all();
    run_frame(pk(50, 50, 50, 50), 64'd0, 16'd0, 16'd0, 16'd256, 4'h0, 1'b0, 1'b0, 1'b0);
    run_frame(pk(50, 50, 50, 50), 64'd0, 16'd0, 16'd0, 16'd256, 4'h0, 1'b1, 1'b0, 1'b0);
    run_frame(pk(20, 20, 20, 20), 64'd0, 16'd0, 16'd0, 16'd256, 4'h0, 1'b1, 1'b0, 1'b0);
    finish_idle();

    // Stop on channel 2 clears its integrator only
    clear_all();
    for (int k = 0; k < 3; k++) begin
      run_frame(pk(10, 10, 10, 10), 64'd0, 16'd0, 16'd256, 16'd0, 4'h0, k > 0, 1'b0, 1'b0);
    end
    run_frame(pk(10, 10, 10, 10), 64'd0, 16'd0, 16'd256, 16'd0, 4'b0100, 1'b1, 1'b0, 1'b0);
    run_frame(pk(10, 10, 10, 10), 64'd0, 16'd0, 16'd256, 16'd0, 4'h0, 1'b1, 1'b0, 1'b0);
    finish_idle();

    // Start while busy is ignored
    run_frame(pk(7, -7, 300, -300), 64'd0, 16'd256, 16'd0, 16'd0, 4'h0, 1'b0, 1'b1, 1'b0);
    finish_idle();

    // Reset mid-frame, then state must restart from zero
    run_frame(pk(300, 40, 40, 40), 64'd0, 16'd256, 16'd256, 16'd0, 4'h0, 1'b0, 1'b0, 1'b1);
    run_frame(pk(10, 10, 10, 10), 64'd0, 16'd0, 16'd256, 16'd0, 4'h0, 1'b0, 1'b0, 1'b0);
    finish_idle();

    // Randomized frames
    open_frame = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        rs = {$urandom, $urandom};
        rf = {$urandom, $urandom};
      end else begin
        for (int n = 0; n < 4; n++) begin
          rs[16*n +: 16] = 16'($urandom_range(0, 400)) - 16'd200;
          rf[16*n +: 16] = 16'($urandom_range(0, 400)) - 16'd200;
        end
      end
      rp = 16'($urandom_range(0, 600));
      ri = 16'($urandom_range(0, 64));
      rd = 16'($urandom_range(0, 600));
      for (int n = 0; n < 4; n++) rst4[n] = ($urandom_range(0, 7) == 0);
      run_frame(rs, rf, rp, ri, rd, rst4, open_frame, 1'b0, 1'b0);
      open_frame = ($urandom_range(0, 1) == 1);
      if (!open_frame) finish_idle();
    end
    if (open_frame) finish_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
